register_file_mp: RTL
=====================

Name: register_file_mp

Overview:
- Parametrised multi-port successor to the datapath's 2-read/1-write register file, for the widened pipeline.
- Adds:
  - configurable width, depth and read-port count;
  - a second write-back port;
  - write-to-read bypass;
  - a per-register pending-write scoreboard, so decode can detect RAW hazards without external tracking.
- Sits between decode (reads, reservations) and write-back (two retire lanes).

Parameters:
- DATA_W, 16, register width in bits
- ADDR_W, 5, address width; depth = 2**ADDR_W
- NUM_RD, 2, number of read ports (1..4)

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset: synchronous, active-low
- rd_addr  in  NUM_RD*ADDR_W  read addresses, port k at bits [k*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  read data, port k at [k*DATA_W +: DATA_W]
- rd_busy  out  NUM_RD  port k's register has an outstanding reservation not cleared this cycle
- wr_en  in  2  write enables, lanes 0 and 1
- wr_addr  in  2*ADDR_W  write addresses
- wr_data  in  2*DATA_W  write data
- rsv_en  in  1  reservation request (decode issuing a producer)
- rsv_addr  in  ADDR_W  destination register to reserve
- rsv_ready  out  1  reservation may be accepted this cycle
- busy_cnt  out  ADDR_W+1  number of currently reserved registers

Behaviour:
- Storage: 2**ADDR_W x DATA_W flops plus 2**ADDR_W busy bits.
- Register 0:
  - always reads 0;
  - writes to 0 are ignored;
  - is never busy;
  - rsv_ready=1 and the reservation is a no-op when rsv_addr=0.
- Reset (rst=0 at a clk edge):
  - all registers and busy bits clear; busy_cnt=0.
  - rd_data follows the cleared state (0 for every address), rd_busy=0, rsv_ready=1.
  - Reset overrides any same-cycle write or reservation.
- Writes: on clk edge, if wr_en[i] and wr_addr[i]!=0, then reg[wr_addr[i]] <= wr_data[i].
  - Both lanes to the same nonzero address: lane 1 wins.
- Reads: combinational, zero latency, write-first bypass.
  - If a lane writes rd_addr[k] (nonzero) this cycle, rd_data[k] = that lane's wr_data, lane 1 over lane 0.
  - Otherwise the stored value.
- Scoreboard:
  - Accepted reservation (rsv_en & rsv_ready, addr!=0) sets busy[rsv_addr] at the edge.
  - Any write lane to a busy register clears that bit at the edge.
  - Writes to non-busy registers still update data and leave busy unchanged.
- rsv_ready = !busy[rsv_addr] | (either write lane targets rsv_addr this cycle). Only one outstanding producer per register.
- Reserve and write to the same address in one cycle, register busy: the clear and set cancel, so busy stays 1 (new producer owns it). Data is still written.
- rsv_en with rsv_ready=0: ignored, no state change. Decode must stall and hold the request.
- rd_busy[k] = busy[rd_addr[k]] & !(a write lane targets rd_addr[k] this cycle). This lets decode consume bypassed data in the retire cycle.
- busy_cnt:
  - registered;
  - next value = current + (set accepted on a non-busy bit) - (number of distinct busy bits cleared);
  - never exceeds 2**ADDR_W-1.

Decomposition:
- Shared package rf_pkg: DATA_W/ADDR_W defaults, NUM_WR=2 constant, zero-register index constant.
- Sub-module rf_scoreboard holds busy bits, rsv_ready, busy_cnt and clear/set arbitration.
- The top keeps the data array, write priority and bypass muxes.

Test Plan:
1. Reset: write reg5=0xBEEF, reserve reg5, assert rst=0 for one edge -> rd_data(5)=0x0000, rd_busy=0, busy_cnt=0, rsv_ready=1.
2. Zero register: wr lane0 addr0 data 0xFFFF, rsv_en addr0 -> reading addr0 gives 0x0000, rd_busy=0, busy_cnt unchanged at 0.
3. Dual-lane collision and bypass:
   - same cycle, lane0 writes reg7=0x1111, lane1 writes reg7=0x2222 -> rd_data(7) shows 0x2222 combinationally in that cycle and after the edge.
4. Scoreboard life cycle:
   - reserve reg3 -> rd_busy=1 on reading 3, busy_cnt=1;
   - second reserve reg3 -> rsv_ready=0, no change;
   - lane0 writes reg3=0x00A5 -> same cycle rd_busy=0, rd_data=0x00A5; next cycle busy_cnt=0.
5. Reserve plus retire same register:
   - reg9 busy; lane1 writes reg9=0x0042 while rsv_en reg9 -> rsv_ready=1;
   - after edge: reg9=0x0042, busy stays 1, busy_cnt stays 1.
6. Parameter sweep: DATA_W=32, ADDR_W=3, NUM_RD=4:
   - reserve regs 1..7 -> busy_cnt=7;
   - two lanes retire 1 and 2 in one cycle -> busy_cnt=5;
   - all 4 read ports return correct independent values.

Source files
------------

// File: rtl/rf_pkg.sv
// -----------------------------------------------------------------------------
// rf_pkg
// Shared constants for the multi-port register file and its scoreboard.
//   DEF_DATA_W / DEF_ADDR_W / DEF_NUM_RD : default parameter values
//   NUM_WR                               : number of write-back (retire) lanes
//   ZERO_REG                             : hard-wired zero register index
// -----------------------------------------------------------------------------
package rf_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_NUM_RD = 2;
  localparam int NUM_WR     = 2;
  localparam int ZERO_REG   = 0;

endpackage : rf_pkg

// File: rtl/rf_scoreboard.sv
// -----------------------------------------------------------------------------
// rf_scoreboard
// Per-register pending-write tracking for the register file. One busy bit per
// register; a reservation from decode sets it, a retire on either write lane
// clears it. Also produces the reservation handshake and a busy-register count.
//
// Ports:
//   clk        in   clock, all state on rising edge
//   rst        in   synchronous reset, active low
//   rd_addr    in   read addresses, port k at [k*ADDR_W +: ADDR_W]
//   rd_busy    out  port k's register is reserved and not retiring this cycle
//   wr_en      in   write enables, one per retire lane
//   wr_addr    in   write addresses, lane i at [i*ADDR_W +: ADDR_W]
//   rsv_en     in   reservation request
//   rsv_addr   in   register to reserve
//   rsv_ready  out  reservation can be accepted this cycle
//   busy_cnt   out  number of registers currently reserved
// -----------------------------------------------------------------------------
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NUM_RD = DEF_NUM_RD
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic                     rsv_en,
  input  logic [ADDR_W-1:0]        rsv_addr,
  output logic                     rsv_ready,
  output logic [ADDR_W:0]          busy_cnt
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DEPTH-1:0] r_busy;
  logic [DEPTH-1:0] w_hit;       // register targeted by an enabled write lane
  logic [DEPTH-1:0] w_set;       // accepted reservation (one-hot or zero)
  logic [DEPTH-1:0] w_clr;       // busy bits actually dropping this edge
  logic [DEPTH-1:0] w_busy_nxt;
  logic [ADDR_W:0]  r_busy_cnt;
  logic [ADDR_W:0]  w_clr_cnt;
  logic [ADDR_W:0]  w_busy_cnt_nxt;
  logic             w_rsv_ready;
  logic             w_set_new;

  // NOTE: every signal written in an always_comb gets a default before any
  // conditional assignment, otherwise a path that skips it infers a latch.
  always_comb begin
    w_hit = '0;
    for (int i = 0; i < NUM_WR; i++) begin
      if (wr_en[i] && (wr_addr[i*ADDR_W +: ADDR_W] != ADDR_W'(ZERO_REG)))
        w_hit[wr_addr[i*ADDR_W +: ADDR_W]] = 1'b1;
    end
  end

  // A retiring write frees the slot in the same cycle, so a new producer can
  // take over the register without a bubble. Register 0 is never busy, so
  // it is always ready.
  assign w_rsv_ready = ~r_busy[rsv_addr] | w_hit[rsv_addr];

  always_comb begin
    w_set = '0;
    if (rsv_en && w_rsv_ready && (rsv_addr != ADDR_W'(ZERO_REG)))
      w_set[rsv_addr] = 1'b1;
  end

  // A set on a retiring register cancels its clear: the new producer owns it.
  assign w_clr      = r_busy & w_hit & ~w_set;
  assign w_busy_nxt = (r_busy & ~w_clr) | w_set;
  assign w_set_new  = |(w_set & ~r_busy);

  always_comb begin
    w_clr_cnt = '0;
    for (int j = 0; j < DEPTH; j++)
      w_clr_cnt = w_clr_cnt + (ADDR_W+1)'(w_clr[j]);
  end

  // Incremental update keeps busy_cnt equal to the population of r_busy.
  assign w_busy_cnt_nxt = r_busy_cnt + (ADDR_W+1)'(w_set_new) - w_clr_cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_busy     <= '0;
      r_busy_cnt <= '0;
    end else begin
      r_busy     <= w_busy_nxt;
      r_busy_cnt <= w_busy_cnt_nxt;
    end
  end

  always_comb begin
    rd_busy = '0;
    for (int k = 0; k < NUM_RD; k++)
      rd_busy[k] = r_busy[rd_addr[k*ADDR_W +: ADDR_W]] &
                   ~w_hit[rd_addr[k*ADDR_W +: ADDR_W]];
  end

  assign rsv_ready = w_rsv_ready;
  assign busy_cnt  = r_busy_cnt;

endmodule : rf_scoreboard

// File: rtl/register_file_mp.sv
// -----------------------------------------------------------------------------
// register_file_mp
// Multi-port register file: NUM_RD combinational read ports with write-first
// bypass, two write-back lanes (lane 1 wins on collision), register 0 tied to
// zero, and a pending-write scoreboard for RAW hazard detection in decode.
//
// Ports:
//   clk        in   clock, all state on rising edge
//   rst        in   synchronous reset, active low
//   rd_addr    in   NUM_RD*ADDR_W  read addresses, port k at [k*ADDR_W +: ADDR_W]
//   rd_data    out  NUM_RD*DATA_W  read data, port k at [k*DATA_W +: DATA_W]
//   rd_busy    out  NUM_RD         port k's register has an unretired producer
//   wr_en      in   2              write enables, lanes 0 and 1
//   wr_addr    in   2*ADDR_W       write addresses
//   wr_data    in   2*DATA_W       write data
//   rsv_en     in   1              reservation request from decode
//   rsv_addr   in   ADDR_W         destination register to reserve
//   rsv_ready  out  1              reservation may be accepted this cycle
//   busy_cnt   out  ADDR_W+1       number of currently reserved registers
// -----------------------------------------------------------------------------
module register_file_mp
  import rf_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NUM_RD = DEF_NUM_RD
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  input  logic                     rsv_en,
  input  logic [ADDR_W-1:0]        rsv_addr,
  output logic                     rsv_ready,
  output logic [ADDR_W:0]          busy_cnt
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] r_regs [DEPTH];

  // NOTE: the array is cleared on reset because the register file is a flop
  // array with a defined post-reset state; a RAM-style memory would not be
  // reset, but this one must read 0 everywhere after reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++)
        r_regs[i] <= '0;
    end else begin
      // Lane 1 is applied last, so it wins when both lanes hit one register.
      for (int i = 0; i < NUM_WR; i++) begin
        if (wr_en[i] && (wr_addr[i*ADDR_W +: ADDR_W] != ADDR_W'(ZERO_REG)))
          r_regs[wr_addr[i*ADDR_W +: ADDR_W]] <= wr_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Read ports: stored value, overridden by a same-cycle write (lane 1 over
  // lane 0), and forced to zero for register 0.
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_val;

    assign w_addr = rd_addr[k*ADDR_W +: ADDR_W];

    always_comb begin
      w_val = r_regs[w_addr];
      for (int i = 0; i < NUM_WR; i++) begin
        if (wr_en[i] && (wr_addr[i*ADDR_W +: ADDR_W] == w_addr))
          w_val = wr_data[i*DATA_W +: DATA_W];
      end
      if (w_addr == ADDR_W'(ZERO_REG))
        w_val = '0;
    end

    assign rd_data[k*DATA_W +: DATA_W] = w_val;
  end

  rf_scoreboard #(
    .ADDR_W (ADDR_W),
    .NUM_RD (NUM_RD)
  ) u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .rd_addr   (rd_addr),
    .rd_busy   (rd_busy),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .rsv_en    (rsv_en),
    .rsv_addr  (rsv_addr),
    .rsv_ready (rsv_ready),
    .busy_cnt  (busy_cnt)
  );

endmodule : register_file_mp
